conv2x2_sequencer: RTL and testbench

Command sequencer for the 2x2 8-bit convolution MAC datapath. Parses a byte-stream command protocol (valid/ready), steers bytes into the datapath weight/input shift registers, waits out the datapath latency, then returns the 18-bit result as two 9-bit beats with backpressure. Sits between the pin-level byte interface and the MAC, and removes the need for an external host to toggle mode pins per byte.

---
 rtl/conv2x2_pkg.sv | 23 ++
 rtl/conv2x2_sequencer.sv | 164 ++++++++++++++++
 tb/tb_conv2x2_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv2x2_pkg.sv
// conv2x2_pkg: shared definitions for the 2x2 convolution command sequencer.
//   state_t   - sequencer FSM states
//   OP_*      - header opcodes carried in s_data[7:6]
//   LANES     - bytes per weight/input group
package conv2x2_pkg;

  typedef enum logic [2:0] {
    ST_HDR    = 3'd0,
    ST_WBYTES = 3'd1,
    ST_XBYTES = 3'd2,
    ST_WAIT   = 3'd3,
    ST_OUT_LO = 3'd4,
    ST_OUT_HI = 3'd5
  } state_t;

  localparam logic [1:0] OP_NOP         = 2'b00;
  localparam logic [1:0] OP_LOAD_W      = 2'b01;
  localparam logic [1:0] OP_CONV        = 2'b10;
  localparam logic [1:0] OP_LOAD_W_CONV = 2'b11;

  localparam int LANES = 4;

endpackage

// File: rtl/conv2x2_sequencer.sv
// conv2x2_sequencer: byte-stream command sequencer for the 2x2 8-bit
// convolution MAC datapath.
//   clk, rst_n          - clock, asynchronous active-low reset
//   flush               - synchronous abort back to header parsing
//   s_data/s_valid/s_ready - command/data byte stream in
//   dp_byte, dp_shift_w, dp_shift_x - byte steering into the datapath
//   dp_result           - datapath convolution sum
//   m_data/m_last/m_valid/m_ready - result out as two RES_W/2-bit beats
//   w_loaded, conv_count, busy - status
module conv2x2_sequencer
  import conv2x2_pkg::*;
#(
  parameter int DP_LATENCY = 1,
  parameter int RES_W      = 18
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [7:0]         dp_byte,
  output logic               dp_shift_w,
  output logic               dp_shift_x,
  input  logic [RES_W-1:0]   dp_result,
  output logic [RES_W/2-1:0] m_data,
  output logic               m_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               w_loaded,
  output logic [7:0]         conv_count,
  output logic               busy
);

  localparam int          HALF_W = RES_W / 2;
  localparam logic [2:0]  LAT    = 3'(DP_LATENCY);
  localparam logic [1:0]  LAST_LANE = 2'(LANES - 1);

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_byte_cnt;
  logic [2:0]          r_wait_cnt;
  logic                r_chain_x;
  logic [RES_W-1:0]    r_hold;
  logic [HALF_W-1:0]   r_m_data;
  logic                r_m_last;
  logic                r_m_valid;
  logic                r_w_loaded;
  logic [7:0]          r_conv_count;

  logic                w_last_byte;
  logic                w_wait_done;
  logic                w_m_hs;

  assign w_last_byte = (r_byte_cnt == LAST_LANE);
  // Counter is loaded with DP_LATENCY >= 1; the capture edge is the one
  // that takes it from 1 to 0.
  assign w_wait_done = (r_wait_cnt <= 3'd1);
  assign w_m_hs      = r_m_valid && m_ready;

  assign dp_byte    = s_data;
  assign m_data     = r_m_data;
  assign m_last     = r_m_last;
  assign m_valid    = r_m_valid;
  assign w_loaded   = r_w_loaded;
  assign conv_count = r_conv_count;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_HDR;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = ST_HDR;
    end else begin
      case (r_state)
        ST_HDR: begin
          if (s_valid) begin
            case (s_data[7:6])
              OP_LOAD_W, OP_LOAD_W_CONV: w_next = ST_WBYTES;
              OP_CONV:                   w_next = ST_XBYTES;
              default:                   w_next = ST_HDR;
            endcase
          end
        end
        ST_WBYTES: if (s_valid && w_last_byte) w_next = r_chain_x ? ST_XBYTES : ST_HDR;
        ST_XBYTES: if (s_valid && w_last_byte) w_next = ST_WAIT;
        ST_WAIT:   if (w_wait_done) w_next = ST_OUT_LO;
        ST_OUT_LO: if (w_m_hs) w_next = ST_OUT_HI;
        ST_OUT_HI: if (w_m_hs) w_next = ST_HDR;
        default:   w_next = ST_HDR;
      endcase
    end
  end

  // Combinational outputs
  always_comb begin
    s_ready    = (r_state == ST_HDR) || (r_state == ST_WBYTES) || (r_state == ST_XBYTES);
    // flush suppresses shifts so an aborted byte never reaches the datapath
    dp_shift_w = (r_state == ST_WBYTES) && s_valid && !flush;
    dp_shift_x = (r_state == ST_XBYTES) && s_valid && !flush;
    busy       = (r_state != ST_HDR);
  end

  // Counters, result hold and registered output beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt   <= '0;
      r_wait_cnt   <= '0;
      r_chain_x    <= 1'b0;
      r_hold       <= '0;
      r_m_data     <= '0;
      r_m_last     <= 1'b0;
      r_m_valid    <= 1'b0;
      r_w_loaded   <= 1'b0;
      r_conv_count <= '0;
    end else if (flush) begin
      r_byte_cnt <= '0;
      r_wait_cnt <= '0;
      r_m_valid  <= 1'b0;
    end else begin
      if (dp_shift_w || dp_shift_x) r_byte_cnt <= r_byte_cnt + 2'd1;

      case (r_state)
        ST_HDR: begin
          if (s_valid) begin
            r_byte_cnt <= '0;
            r_chain_x  <= (s_data[7:6] == OP_LOAD_W_CONV);
          end
        end
        ST_WBYTES: if (s_valid && w_last_byte) r_w_loaded <= 1'b1;
        ST_XBYTES: if (s_valid && w_last_byte) r_wait_cnt <= LAT;
        ST_WAIT: begin
          r_wait_cnt <= r_wait_cnt - 3'd1;
          if (w_wait_done) r_hold <= dp_result;
        end
        ST_OUT_LO: begin
          // First cycle in OUT_LO presents the low half; a handshake
          // swaps straight to the high half without a bubble.
          if (!r_m_valid) begin
            r_m_data  <= r_hold[HALF_W-1:0];
            r_m_last  <= 1'b0;
            r_m_valid <= 1'b1;
          end else if (m_ready) begin
            r_m_data <= r_hold[RES_W-1:HALF_W];
            r_m_last <= 1'b1;
          end
        end
        ST_OUT_HI: begin
          if (w_m_hs) begin
            r_m_valid    <= 1'b0;
            r_conv_count <= r_conv_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2x2_sequencer.sv
module tb_conv2x2_sequencer;

  localparam int RES_W = 18;
  localparam int HALF  = RES_W / 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic [7:0]       s_data;
  logic             s_valid;
  logic             s_ready;
  logic [7:0]       dp_byte;
  logic             dp_shift_w;
  logic             dp_shift_x;
  logic [RES_W-1:0] dp_result;
  logic [HALF-1:0]  m_data;
  logic             m_last;
  logic             m_valid;
  logic             m_ready;
  logic             w_loaded;
  logic [7:0]       conv_count;
  logic             busy;

  always #5 clk = ~clk;

  conv2x2_sequencer #(.DP_LATENCY(1), .RES_W(RES_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .dp_byte(dp_byte), .dp_shift_w(dp_shift_w), .dp_shift_x(dp_shift_x),
    .dp_result(dp_result),
    .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .w_loaded(w_loaded), .conv_count(conv_count), .busy(busy)
  );

  // MAC datapath peer: shift in at the MSB end, combinational sum (latency 1)
  logic [31:0] dp_w_sr, dp_x_sr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_w_sr <= '0;
      dp_x_sr <= '0;
    end else begin
      if (dp_shift_w) dp_w_sr <= {dp_byte, dp_w_sr[31:8]};
      if (dp_shift_x) dp_x_sr <= {dp_byte, dp_x_sr[31:8]};
    end
  end
  always_comb begin
    int acc;
    acc = 0;
    for (int i = 0; i < 4; i++) acc = acc + int'(dp_w_sr[8*i +: 8]) * int'(dp_x_sr[8*i +: 8]);
    dp_result = acc[RES_W-1:0];
  end

  // Output sink: random or manual ready, changed 2 ns after the edge
  logic auto_rdy, rnd_rdy, man_rdy;
  assign m_ready = auto_rdy ? rnd_rdy : man_rdy;
  always @(posedge clk) begin
    #2;
    rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  // Monitor: observe at the falling edge what the next rising edge commits
  logic [HALF:0] got_q[$];
  int            n_wshift = 0;
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready && !flush) got_q.push_back({m_last, m_data});
    if (rst_n && dp_shift_w) n_wshift = n_wshift + 1;
  end

  // Reference model
  int            n_checks = 0;
  int            n_errors = 0;
  int            mw[4];
  int            mx[4];
  int            model_count;
  bit            model_wl;
  logic [HALF:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done;
    done    = 1'b0;
    s_data  = b;
    s_valid = 1'b1;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    s_valid = 1'b0;
    if (!done) check_val("s_ready_timeout", 0, 1);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mw[i] = 0;
      mx[i] = 0;
    end
    model_count = 0;
    model_wl    = 1'b0;
    exp_q.delete();
  endtask

  task automatic send_frame(input logic [1:0] op, input logic [31:0] wv, input logic [31:0] xv);
    int            sum;
    logic [RES_W-1:0] r;
    send_byte({op, 6'($urandom)});
    if (op == 2'b01 || op == 2'b11) begin
      for (int i = 0; i < 4; i++) begin
        idle($urandom_range(0, 2));
        send_byte(wv[8*i +: 8]);
        mw[i] = int'(wv[8*i +: 8]);
      end
      model_wl = 1'b1;
    end
    if (op == 2'b10 || op == 2'b11) begin
      for (int i = 0; i < 4; i++) begin
        idle($urandom_range(0, 2));
        send_byte(xv[8*i +: 8]);
        mx[i] = int'(xv[8*i +: 8]);
      end
      sum = 0;
      for (int i = 0; i < 4; i++) sum += mw[i] * mx[i];
      r = sum[RES_W-1:0];
      exp_q.push_back({1'b0, r[HALF-1:0]});
      exp_q.push_back({1'b1, r[RES_W-1:HALF]});
      model_count++;
    end
  endtask

  task automatic drain(input string tag);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      if (got_q.size() >= exp_q.size() && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_val({tag, "_timeout"}, 0, 1);
    idle(4);
    check_val({tag, "_beats"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check_val({tag, "_beat"}, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
    check_val({tag, "_count"}, conv_count, model_count % 256);
    check_val({tag, "_wloaded"}, w_loaded, model_wl);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_m_valid"}, m_valid, 0);
    check_val({tag, "_m_last"}, m_last, 0);
    check_val({tag, "_m_data"}, m_data, 0);
    check_val({tag, "_w_loaded"}, w_loaded, 0);
    check_val({tag, "_conv_count"}, conv_count, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_s_ready"}, s_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [HALF-1:0] d0;
    logic            l0;
    bit              seen;
    int              base;

    rst_n = 1'b1; flush = 1'b0; s_data = '0; s_valid = 1'b0;
    auto_rdy = 1'b1; man_rdy = 1'b0; rnd_rdy = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #11;
    check_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    idle(1);
    check_reset_outputs("post_reset");

    // Weights 1..4, inputs 5..8 -> 70
    send_frame(2'b11, 32'h04030201, 32'h08070605);
    drain("basic");

    // All 0xFF -> 260100
    send_frame(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);
    drain("allff");

    // Backpressure: hold both beats
    auto_rdy = 1'b0; man_rdy = 1'b0;
    send_frame(2'b11, $urandom, $urandom);
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (m_valid) begin seen = 1'b1; break; end
    end
    check_val("stall_lo_seen", seen, 1);
    d0 = m_data; l0 = m_last;
    check_val("stall_lo_last", l0, 0);
    repeat (10) begin
      @(negedge clk);
      check_val("stall_lo_data", m_data, d0);
      check_val("stall_lo_lastst", m_last, l0);
      check_val("stall_lo_valid", m_valid, 1);
      check_val("stall_lo_sready", s_ready, 0);
    end
    @(posedge clk); #2 man_rdy = 1'b1;
    @(posedge clk); #2 man_rdy = 1'b0;
    @(negedge clk);
    d0 = m_data; l0 = m_last;
    check_val("stall_hi_last", l0, 1);
    check_val("stall_hi_valid", m_valid, 1);
    repeat (5) begin
      @(negedge clk);
      check_val("stall_hi_data", m_data, d0);
      check_val("stall_hi_lastst", m_last, l0);
      check_val("stall_hi_sready", s_ready, 0);
    end
    @(posedge clk); #2 man_rdy = 1'b1;
    @(posedge clk); #2 man_rdy = 1'b0;
    auto_rdy = 1'b1;
    idle(1);
    drain("stall");

    // NOP then CONV reusing weights 1..4 with inputs 1,1,1,1 -> 10
    send_frame(2'b01, 32'h04030201, 32'h0);
    idle(2);
    base = n_wshift;
    send_frame(2'b00, 32'h0, 32'h0);
    check_val("nop_busy", busy, 0);
    send_frame(2'b10, 32'h0, 32'h01010101);
    drain("nop_conv");
    check_val("nop_conv_wshift", n_wshift - base, 0);

    // Flush with a header present in HDR: consumed as NOP
    flush = 1'b1; s_valid = 1'b1; s_data = 8'hC0;
    @(negedge clk);
    check_val("flush_hdr_shift", dp_shift_w, 0);
    @(posedge clk); #1 flush = 1'b0; s_valid = 1'b0;
    check_val("flush_hdr_busy", busy, 0);

    // Flush midway through a weight group, then full reload
    send_byte(8'h40);
    send_byte(8'h11);
    send_byte(8'h22);
    flush = 1'b1; s_valid = 1'b1; s_data = 8'h33;
    @(negedge clk);
    check_val("flush_w_shift", dp_shift_w, 0);
    @(posedge clk); #1 flush = 1'b0; s_valid = 1'b0;
    check_val("flush_w_busy", busy, 0);
    send_frame(2'b01, 32'h04030201, 32'h0);

    // Flush after the 2nd input byte, then resend the full CONV
    send_byte(8'h80);
    send_byte(8'h09);
    send_byte(8'h0A);
    flush = 1'b1; s_valid = 1'b1; s_data = 8'h0B;
    @(negedge clk);
    check_val("flush_x_shift", dp_shift_x, 0);
    @(posedge clk); #1 flush = 1'b0; s_valid = 1'b0;
    check_val("flush_x_busy", busy, 0);
    send_frame(2'b10, 32'h0, 32'h0D0C0B0A);
    drain("flush_resend");

    // Randomized command mix
    for (int k = 0; k < 30; k++) begin
      send_frame(2'($urandom_range(0, 3)), $urandom, $urandom);
      if (k % 5 == 4) drain("rand");
    end
    drain("rand_end");

    // Asynchronous reset while waiting for the datapath
    send_frame(2'b10, 32'h0, $urandom);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
    got_q.delete();
    idle(10);
    check_val("async_rst_nobeat", got_q.size(), 0);
    send_frame(2'b10, 32'h0, 32'h05050505);
    drain("after_rst_zero_w");
    send_frame(2'b11, $urandom, $urandom);
    drain("after_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
